// File: rtl/param_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// Contents: FSM state encoding and the iteration-counter width helper.
// No logic of its own; imported by the divider top.
package param_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size a counter that must hold the value WIDTH.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/param_divider_if.sv
// Start/ready handshake bundle between a requester and the divider.
// master: drives start, interrupt, signed_mode, operandA, operandB.
// slave:  drives quotient, remainder, ready, busy, exception, overflow.
interface param_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             interrupt;
    logic             signed_mode;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             ready;
    logic             busy;
    logic             exception;
    logic             overflow;

    modport master (
        output start, interrupt, signed_mode, operandA, operandB,
        input  quotient, remainder, ready, busy, exception, overflow
    );

    modport slave (
        input  start, interrupt, signed_mode, operandA, operandB,
        output quotient, remainder, ready, busy, exception, overflow
    );

endinterface

// File: rtl/param_divider_div_restore_step.sv
// One restoring-division iteration on magnitudes (purely combinational).
// Latency: 0 cycles. Backpressure: none, evaluated every cycle.
// Ports: rem/q/divisor in -> rem_next/q_next out (q shifts in the new bit).
module div_restore_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < divisor always holds between steps, so the WIDTH+1 bit trial
    // difference never wraps: its MSB is a true sign bit.
    always_comb begin
        shifted = {rem, q[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/param_divider.sv
// Iterative restoring divider, signed/unsigned, with remainder and flags.
// Latency: WIDTH+1 cycles start->ready (1 cycle for divide-by-zero).
// Backpressure: none; start restarts at any time, interrupt aborts BUSY.
// Ports: clk, reset (async active-high), bus (param_divider_if.slave).
module param_divider
    import param_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    param_divider_if.slave bus
);

    localparam int               CW      = clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH-1:0] div_reg;
    logic             q_neg;
    logic             r_neg;
    logic             ovf_pend;

    logic             launch;
    logic             abort;
    logic             div_zero;
    logic             last;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] q_step;

    // interrupt takes priority over a simultaneous start in every state.
    assign launch   = bus.start & ~bus.interrupt;
    assign abort    = bus.interrupt & (state == BUSY);
    assign div_zero = (div_reg == '0);
    assign last     = (cnt == CW'(WIDTH));

    // Negating MIN yields the MIN pattern, which read as unsigned is the
    // correct magnitude 2^(WIDTH-1).
    assign a_neg = bus.signed_mode & bus.operandA[WIDTH-1];
    assign b_neg = bus.signed_mode & bus.operandB[WIDTH-1];
    assign a_abs = a_neg ? -bus.operandA : bus.operandA;
    assign b_abs = b_neg ? -bus.operandB : bus.operandB;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_reg),
        .q        (quo_sr),
        .divisor  (div_reg),
        .rem_next (rem_step),
        .q_next   (q_step)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else if (launch) begin
            state_next = BUSY;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                BUSY:    if (div_zero || last) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        case (state)
            BUSY:    bus.busy  = 1'b1;
            DONE:    bus.ready = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, iteration, sign correction.
    // signed_mode only matters through the captured signs and the MIN/-1
    // detection, so it is not stored separately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            rem_reg       <= '0;
            quo_sr        <= '0;
            div_reg       <= '0;
            q_neg         <= 1'b0;
            r_neg         <= 1'b0;
            ovf_pend      <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.exception <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (abort) begin
            // Drop the operation; visible results keep their old values.
        end else if (launch) begin
            div_reg       <= b_abs;
            quo_sr        <= a_abs;
            rem_reg       <= '0;
            cnt           <= '0;
            q_neg         <= a_neg ^ b_neg;
            r_neg         <= a_neg;
            ovf_pend      <= bus.signed_mode && (bus.operandA == MIN_VAL) &&
                             (bus.operandB == '1);
            bus.exception <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (state == BUSY) begin
            if (div_zero) begin
                // quo_sr still holds |A|; re-applying the sign restores A.
                bus.quotient  <= '0;
                bus.remainder <= r_neg ? -quo_sr : quo_sr;
                bus.exception <= 1'b1;
                bus.overflow  <= 1'b0;
            end else if (last) begin
                bus.quotient  <= q_neg ? -quo_sr : quo_sr;
                bus.remainder <= r_neg ? -rem_reg : rem_reg;
                bus.overflow  <= ovf_pend;
            end else begin
                rem_reg <= rem_step;
                quo_sr  <= q_step;
                cnt     <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/param_divider.md
Name: param_divider

Overview:
- Parametrised iterative restoring divider, the successor to the fixed 32-bit signed divider in the multdiv unit.
- Adds: WIDTH generic, per-operation signed/unsigned mode, remainder output, a separate overflow flag, a busy indicator, and defined restart/abort semantics.
- Sits beside the multiplier behind the same start/ready/interrupt handshake; one quotient bit is resolved per clock.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (>= 4)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces IDLE and clears all registers
start  input  1  launch a division, sampled on clk
interrupt  input  1  abort the operation in flight, sampled on clk
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured on start
operandA  input  WIDTH  dividend, captured on start
operandB  input  WIDTH  divisor, captured on start
quotient  output  WIDTH  registered result, truncated toward zero
remainder  output  WIDTH  registered remainder, sign follows dividend (signed mode)
ready  output  1  level; high in DONE
busy  output  1  level; high in BUSY
exception  output  1  divide-by-zero flag, valid while ready
overflow  output  1  signed MIN / -1 flag, valid while ready

Behaviour:
- Reset: state IDLE; quotient, remainder, ready, busy, exception, overflow = 0; internal registers cleared. Reset mid-operation discards the work in flight.
- States: IDLE, BUSY, DONE.
- Launch: start sampled at edge k, from any state.
  - Captures |A|, |B|, the quotient sign (signA xor signB, signed mode only), the remainder sign (signA, signed mode only) and signed_mode.
  - Loads the partial remainder with 0 and the quotient shift register with |A|.
  - Sets iteration counter = 0, goes to BUSY, clears ready/exception/overflow.
- Restart: start while BUSY re-launches with the new operands and discards the old ones.
- Abort: interrupt at an edge in BUSY goes to IDLE. ready stays 0; quotient and remainder hold their previous values.
  - interrupt and start in the same cycle: interrupt wins, start is ignored.
  - interrupt in IDLE or DONE has no effect.
- Iteration (edges k+1 .. k+WIDTH, BUSY):
  - Shift {rem, q} left by 1.
  - Trial difference = rem - |B|, at WIDTH+1 bits.
  - Difference non-negative: rem = diff and q LSB = 1; otherwise keep rem and q LSB = 0.
  - Counter increments.
- Completion (edge k+WIDTH+1):
  - Conditionally negate q and rem per the captured signs and register them into quotient/remainder.
  - Go to DONE, ready = 1, busy = 0.
  - Total latency is WIDTH+1 cycles from the start edge to ready visible.
- Divide by zero (captured |B| == 0): edge k+1 goes directly to DONE with exception = 1, quotient = 0, remainder = operandA as captured, overflow = 0. Latency is 1 cycle.
- Overflow (signed_mode, A = 2^(WIDTH-1) pattern, B = all ones):
  - Normal iteration and latency.
  - quotient = 2^(WIDTH-1) pattern (wraps), remainder = 0, overflow = 1.
- Magnitude of the signed MIN value is taken as its unsigned pattern, so no internal overflow occurs; the datapath is WIDTH+1 bits wide.
- DONE holds all outputs until the next start or reset; the IDLE to DONE outputs are stable.
- busy = 1 exactly while in BUSY. ready and busy are never both 1.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the counter-width function clog2(WIDTH+1).
- Sub-module div_restore_step: combinational single restoring iteration. Inputs rem, q, divisor; outputs next rem, next q.
- FSM, counter and sign correction stay in param_divider.

Test Plan:
- WIDTH=32, signed, A=100, B=7, start 1 cycle -> ready after 33 cycles, quotient=14, remainder=2, flags 0.
- WIDTH=32, signed, A=-100, B=7 -> quotient=-14, remainder=-2. Then unsigned with A=0xFFFFFF9C, B=7 -> quotient=613566742, remainder=2.
- WIDTH=8, signed, A=0x80, B=0xFF -> ready after 9 cycles, quotient=0x80, remainder=0, overflow=1. Then A=5, B=0 -> ready after 1 cycle, exception=1, quotient=0, remainder=5.
- WIDTH=16: start, interrupt at cycle 5 -> busy drops, ready never rises, outputs unchanged. start and interrupt together in IDLE -> stays IDLE.
- WIDTH=16: start A=1000 B=3, re-start at cycle 8 with A=50 B=5 -> ready 17 cycles after the second start, quotient=10, remainder=0.
- Assert reset mid-BUSY (async, between edges) -> outputs 0 immediately. After release, start A=9 B=2 -> quotient=4, remainder=1.
